// File: rtl/hdb3_decoder_pkg.sv
// Shared constants for the HDB3 line decoder: reset level, line symbol codes,
// polarity encoding and pipeline depth.
package hdb3_decoder_pkg;

  localparam logic RST_EN = 1'b1;

  localparam int HDB3_LATENCY = 3;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_N    = 2'b01,
    SYM_P    = 2'b10,
    SYM_ILL  = 2'b11
  } sym_e;

  localparam logic POL_P = 1'b0;
  localparam logic POL_N = 1'b1;

  localparam logic [2:0] ZC_MAX = 3'd4;

endpackage

// File: rtl/hdb3_v_detect.sv
// Tracks pulse polarity and zero runs; classifies the current line symbol as
// mark, violation or code error (combinational outputs for the current sample).
module hdb3_v_detect
  import hdb3_decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sym,
  output logic       mark,
  output logic       v_pulse,
  output logic       err
);

  logic       last_pol_q, last_pol_d;
  logic       seen_q, seen_d;
  logic [2:0] zc_q, zc_d;
  logic       pol;

  always_comb begin
    last_pol_d = last_pol_q;
    seen_d     = seen_q;
    zc_d       = zc_q;
    mark       = 1'b0;
    v_pulse    = 1'b0;
    err        = 1'b0;
    pol        = (sym == SYM_N) ? POL_N : POL_P;
    case (sym)
      SYM_ZERO: begin
        zc_d = (zc_q >= ZC_MAX) ? ZC_MAX : zc_q + 3'd1;
        // Fourth zero in a row, and every zero after it, is a code error.
        err  = (zc_q >= 3'd3);
      end
      SYM_P, SYM_N: begin
        v_pulse    = seen_q && (pol == last_pol_q);
        mark       = !v_pulse;
        err        = v_pulse && !((zc_q == 3'd2) || (zc_q == 3'd3));
        last_pol_d = pol;
        seen_d     = 1'b1;
        zc_d       = 3'd0;
      end
      SYM_ILL: begin
        // Illegal symbol leaves polarity and zero-run state untouched.
        err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n == RST_EN) begin
      last_pol_q <= POL_P;
      seen_q     <= 1'b0;
      zc_q       <= 3'd0;
    end else begin
      last_pol_q <= last_pol_d;
      seen_q     <= seen_d;
      zc_q       <= zc_d;
    end
  end

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 decoder top: bipolar line symbols in, NRZ bits out after LATENCY clocks;
// a violation clears the bit LATENCY symbols back (the B of B00V).
module hdb3_decoder
  import hdb3_decoder_pkg::*;
#(
  parameter int LATENCY = HDB3_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic BP,
  input  logic BN,
  output logic data_out,
  output logic data_valid,
  output logic v_det,
  output logic code_err
);

  logic [LATENCY:0] sr_q, sr_d;
  logic [2:0]       fill_q, fill_d;
  logic             data_valid_q, data_valid_d;
  logic             v_det_q, v_det_d;
  logic             code_err_q, code_err_d;
  logic             mark, v_pulse, err;

  hdb3_v_detect u_v_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .sym     ({BP, BN}),
    .mark    (mark),
    .v_pulse (v_pulse),
    .err     (err)
  );

  always_comb begin
    sr_d         = {(v_pulse ? 1'b0 : sr_q[LATENCY-1]), sr_q[LATENCY-2:0], mark};
    fill_d       = (fill_q == 3'd7) ? fill_q : fill_q + 3'd1;
    data_valid_d = (fill_q >= 3'(LATENCY));
    v_det_d      = v_pulse;
    code_err_d   = err;
  end

  always_ff @(posedge clk) begin
    if (rst_n == RST_EN) begin
      sr_q         <= '0;
      fill_q       <= 3'd0;
      data_valid_q <= 1'b0;
      v_det_q      <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      data_valid_q <= data_valid_d;
      v_det_q      <= v_det_d;
      code_err_q   <= code_err_d;
    end
  end

  assign data_out   = sr_q[LATENCY];
  assign data_valid = data_valid_q;
  assign v_det      = v_det_q;
  assign code_err   = code_err_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Scoreboard bench for hdb3_decoder: per-symbol expectations are queued at drive
// time and popped when the decoder's outputs for that symbol are due.
module tb_hdb3_decoder;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic BP = 1'b0;
  logic BN = 1'b0;
  logic data_out, data_valid, v_det, code_err;

  typedef struct {
    int   due;
    logic b;
    string tag;
  } dexp_t;

  dexp_t      data_q[$];
  logic [1:0] ve_q[$];
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int rel    = 0;

  hdb3_decoder #(.LATENCY(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BP         (BP),
    .BN         (BN),
    .data_out   (data_out),
    .data_valid (data_valid),
    .v_det      (v_det),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    {BP, BN} = 2'b00;
    @(posedge clk);
    edge_n++;
    #1;
    check_eq({tag, "/rst_data"},  data_out,   0);
    check_eq({tag, "/rst_valid"}, data_valid, 0);
    check_eq({tag, "/rst_vdet"},  v_det,      0);
    check_eq({tag, "/rst_err"},   code_err,   0);
    data_q.delete();
    ve_q.delete();
    rel = 0;
  endtask

  task automatic step(input logic [1:0] sym, input logic eb, input logic ev, input logic ee,
                      input string tag);
    dexp_t      d;
    logic [1:0] ve;
    @(negedge clk);
    rst_n = 1'b0;
    {BP, BN} = sym;
    d.due = edge_n + 1 + LAT;
    d.b   = eb;
    d.tag = tag;
    data_q.push_back(d);
    ve_q.push_back({ev, ee});
    @(posedge clk);
    edge_n++;
    rel++;
    #1;
    ve = ve_q.pop_front();
    check_eq({tag, "/v_det"},    v_det,      ve[1]);
    check_eq({tag, "/code_err"}, code_err,   ve[0]);
    check_eq({tag, "/valid"},    data_valid, (rel >= LAT + 1) ? 1 : 0);
    if (data_q.size() > 0 && data_q[0].due == edge_n) begin
      d = data_q.pop_front();
      check_eq({d.tag, "/data"}, data_out, d.b);
    end
  endtask

  // syms: P, N, 0 or I(llegal); bits/vs/es: '1' or '0' per symbol.
  task automatic run_seq(input string tag, input string syms, input string bits,
                         input string vs, input string es);
    logic [1:0] s;
    for (int i = 0; i < syms.len(); i++) begin
      case (syms[i])
        "P":     s = 2'b10;
        "N":     s = 2'b01;
        "I":     s = 2'b11;
        default: s = 2'b00;
      endcase
      step(s, bits[i] == "1", vs[i] == "1", es[i] == "1", $sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    do_reset("init0");
    do_reset("init1");

    run_seq("marks", "P0N0P000",    "10101000",    "00000000",    "00000000");
    do_reset("r1");
    run_seq("v000",  "PN000N000",   "110000000",   "000001000",   "000000000");
    do_reset("r2");
    run_seq("b00v",  "PNPNP00P000", "11110000000", "00000001000", "00000000000");
    do_reset("r3");
    run_seq("ill",   "PNIP000",     "1101000",     "0000000",     "0010000");
    do_reset("r4");
    run_seq("zrun",  "P00000000",   "100000000",   "000000000",   "000011111");
    do_reset("r5");
    run_seq("badv",  "PN0N000",     "0100000",     "0001000",     "0001000");
    do_reset("r6");
    run_seq("pre",   "PNPNP0",      "111110",      "000000",      "000000");
    do_reset("mid");
    run_seq("post",  "PNPN000",     "1111000",     "0000000",     "0000000");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
